// File: rtl/strobe_divider_bank_pkg.sv
// Shared types and constants for the strobe divider bank.
package strobe_pkg;

    typedef enum logic {
        STB_PERIODIC = 1'b0,
        STB_ONESHOT  = 1'b1
    } strobe_mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } strobe_state_e;

    // Smallest ratio a channel will run at; smaller requests are clamped.
    localparam int unsigned MIN_DIV = 2;

endpackage : strobe_pkg

// File: rtl/strobe_divider_bank_if.sv
// Control/status bundle for the strobe divider bank.
interface strobe_divider_bank_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 32
);
    logic [N_CH-1:0]            i_en;
    logic [N_CH-1:0]            i_mode;
    logic [N_CH-1:0][WIDTH-1:0] i_div;
    logic [N_CH-1:0]            i_start;
    logic                       i_sync;
    logic [N_CH-1:0]            o_stb;
    logic [N_CH-1:0]            o_busy;
    logic [N_CH-1:0]            o_err;

    // Controller side: drives configuration, observes strobes.
    modport master (
        output i_en, i_mode, i_div, i_start, i_sync,
        input  o_stb, o_busy, o_err
    );

    // Divider bank side.
    modport slave (
        input  i_en, i_mode, i_div, i_start, i_sync,
        output o_stb, o_busy, o_err
    );
endinterface : strobe_divider_bank_if

// File: rtl/strobe_divider_bank_channel.sv
// One strobe channel: IDLE/RUN down-counter producing a single-cycle
// strobe every div cycles (periodic) or once per start (one-shot).
module strobe_channel
    import strobe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_start,
    input  logic             i_sync,
    output logic             o_stb,
    output logic             o_busy,
    output logic             o_err
);

    strobe_state_e    state_q;
    strobe_mode_e     mode_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] div_q;
    logic             stb_q;
    logic             busy_q;
    logic             err_q;

    logic [WIDTH-1:0] div_d;
    logic             div_low;

    // Ratio presented to the next load event, clamped to MIN_DIV.
    always_comb begin
        div_low = (i_div < WIDTH'(MIN_DIV));
        div_d   = div_low ? WIDTH'(MIN_DIV) : i_div;
    end

    // Channel state machine; all outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= STB_PERIODIC;
            cnt_q   <= '0;
            div_q   <= WIDTH'(MIN_DIV);
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (!i_en) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (strobe_mode_e'(i_mode) == STB_PERIODIC || i_start) begin
                        state_q <= ST_RUN;
                        mode_q  <= strobe_mode_e'(i_mode);
                        div_q   <= div_d;
                        cnt_q   <= div_d - WIDTH'(1);
                        busy_q  <= 1'b1;
                        err_q   <= err_q | div_low;
                    end
                end
                ST_RUN: begin
                    if (i_sync) begin
                        // Restart the period; any strobe due now is dropped.
                        mode_q <= strobe_mode_e'(i_mode);
                        div_q  <= div_d;
                        cnt_q  <= div_d - WIDTH'(1);
                        err_q  <= err_q | div_low;
                    end else if (cnt_q == '0) begin
                        stb_q <= 1'b1;
                        if (mode_q == STB_PERIODIC) begin
                            mode_q <= strobe_mode_e'(i_mode);
                            div_q  <= div_d;
                            cnt_q  <= div_d - WIDTH'(1);
                            err_q  <= err_q | div_low;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - WIDTH'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // div_q records the ratio in force for the running period; the counter
    // is preloaded from the same value, so it is kept for observability only.
    logic unused_div;
    assign unused_div = ^div_q;

    assign o_stb  = stb_q;
    assign o_busy = busy_q;
    assign o_err  = err_q;

endmodule : strobe_channel

// File: rtl/strobe_divider_bank.sv
// Top level: one strobe_channel per channel, sliced from the bus interface.
module strobe_divider_bank
    import strobe_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    strobe_divider_bank_if.slave bus
);

    // Per-channel instances; i_sync is shared by all of them.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        strobe_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (bus.i_en[c]),
            .i_mode  (bus.i_mode[c]),
            .i_div   (bus.i_div[c]),
            .i_start (bus.i_start[c]),
            .i_sync  (bus.i_sync),
            .o_stb   (bus.o_stb[c]),
            .o_busy  (bus.o_busy[c]),
            .o_err   (bus.o_err[c])
        );
    end

endmodule : strobe_divider_bank

// File: tb/tb_strobe_divider_bank.sv
// Directed bench for strobe_divider_bank with hand-computed expectations.
module tb_strobe_divider_bank;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    strobe_divider_bank_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    strobe_divider_bank #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick n edges; channel ch must strobe only on the n-th.
    task automatic strobe_after(input string tag, input int ch, input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk(tag, 32'(bus.o_stb[ch]), 32'(i == n));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.i_en    = '0;
        bus.i_mode  = '0;
        bus.i_div   = '0;
        bus.i_start = '0;
        bus.i_sync  = 1'b0;

        tick();
        tick();
        chk("rst_stb",  32'(bus.o_stb),  32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_err",  32'(bus.o_err),  32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_stb", 32'(bus.o_stb), 32'h0);

        // Periodic, div 5: load edge then strobes every 5 edges.
        bus.i_div[0] = 32'd5;
        bus.i_en[0]  = 1'b1;
        tick();
        chk("p5_busy", 32'(bus.o_busy), 32'h1);
        chk("p5_err",  32'(bus.o_err),  32'h0);
        strobe_after("p5_s1", 0, 5);
        // Change ratio mid-period: current period unaffected, then 3.
        tick();
        chk("p5_mid0", 32'(bus.o_stb[0]), 32'h0);
        tick();
        chk("p5_mid1", 32'(bus.o_stb[0]), 32'h0);
        bus.i_div[0] = 32'd3;
        strobe_after("p5_s2", 0, 3);
        strobe_after("p3_s1", 0, 3);
        strobe_after("p3_s2", 0, 3);
        bus.i_en[0] = 1'b0;
        tick();
        chk("dis_busy", 32'(bus.o_busy), 32'h0);
        chk("dis_stb",  32'(bus.o_stb),  32'h0);

        // One-shot, div 4, with a second start while running.
        bus.i_mode[1]  = 1'b1;
        bus.i_div[1]   = 32'd4;
        bus.i_en[1]    = 1'b1;
        tick();
        chk("os_nostart", 32'(bus.o_busy), 32'h0);
        bus.i_start[1] = 1'b1;
        tick();
        chk("os_busy", 32'(bus.o_busy), 32'h2);
        bus.i_start[1] = 1'b0;
        tick();
        bus.i_start[1] = 1'b1;
        tick();
        chk("os_run", 32'(bus.o_stb), 32'h0);
        bus.i_start[1] = 1'b0;
        tick();
        chk("os_pre", 32'(bus.o_stb), 32'h0);
        tick();
        chk("os_stb",   32'(bus.o_stb),  32'h2);
        chk("os_fall",  32'(bus.o_busy), 32'h0);
        tick();
        chk("os_once",  32'(bus.o_stb),  32'h0);
        chk("os_idle",  32'(bus.o_busy), 32'h0);
        bus.i_en[1]   = 1'b0;
        bus.i_mode[1] = 1'b0;
        tick();

        // Sync with ch2 div 4 and ch3 div 6 running.
        bus.i_div[2] = 32'd4;
        bus.i_div[3] = 32'd6;
        bus.i_en[2]  = 1'b1;
        bus.i_en[3]  = 1'b1;
        tick();
        chk("sy_busy", 32'(bus.o_busy), 32'hC);
        tick();
        tick();
        bus.i_sync = 1'b1;
        tick();
        chk("sy_edge", 32'(bus.o_stb), 32'h0);
        bus.i_sync = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("sy_ch2", 32'(bus.o_stb[2]), 32'(i == 4));
            chk("sy_ch3", 32'(bus.o_stb[3]), 32'(i == 6));
        end
        // ch2 is at terminal count two edges later; sync there drops it.
        tick();
        bus.i_sync = 1'b1;
        tick();
        chk("sy_tc", 32'(bus.o_stb[2]), 32'h0);
        bus.i_sync = 1'b0;
        strobe_after("sy_rel", 2, 4);
        bus.i_en[2] = 1'b0;
        bus.i_en[3] = 1'b0;
        tick();
        chk("sy_off", 32'(bus.o_busy), 32'h0);

        // Ratios 0 and 1 clamp to 2 and flag an error.
        bus.i_div[0] = 32'd0;
        bus.i_div[1] = 32'd1;
        bus.i_en[0]  = 1'b1;
        bus.i_en[1]  = 1'b1;
        tick();
        chk("lo_err", 32'(bus.o_err), 32'h3);
        strobe_after("lo_d0a", 0, 2);
        chk("lo_d1a", 32'(bus.o_stb[1]), 32'h1);
        strobe_after("lo_d0b", 0, 2);
        chk("lo_d1b", 32'(bus.o_stb[1]), 32'h1);
        tick();
        bus.i_en[0] = 1'b0;
        bus.i_en[1] = 1'b0;
        tick();
        chk("lo_dstb", 32'(bus.o_stb),  32'h0);
        chk("lo_derr", 32'(bus.o_err),  32'h0);
        chk("lo_dbsy", 32'(bus.o_busy), 32'h0);

        // Reset landing on the terminal-count edge, then restart.
        bus.i_div[0] = 32'd5;
        bus.i_en[0]  = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("mr_stb",  32'(bus.o_stb),  32'h0);
        chk("mr_busy", 32'(bus.o_busy), 32'h0);
        chk("mr_err",  32'(bus.o_err),  32'h0);
        rst_n = 1'b1;
        tick();
        chk("mr_load", 32'(bus.o_busy), 32'h1);
        strobe_after("mr_s1", 0, 5);
        strobe_after("mr_s2", 0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_strobe_divider_bank
